// File: rtl/llc_dma_ctx_regs_if.sv
// llc_dma_ctx_regs_if: request/issue/free bus and per-slot status of the DMA context block
interface llc_dma_ctx_regs_if #(
  parameter int N_CTX  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  localparam int ID_W = $clog2(N_CTX);
  logic                    alloc_valid;
  logic [ADDR_W-1:0]       alloc_addr;
  logic [LEN_W-1:0]        alloc_len;
  logic                    alloc_is_write;
  logic                    alloc_ready;
  logic [ID_W-1:0]         alloc_id;
  logic                    issue_en;
  logic [ID_W-1:0]         issue_id;
  logic                    free_en;
  logic [ID_W-1:0]         free_id;
  logic                    set_recall_pending;
  logic                    clr_recall_pending;
  logic                    recall_pending;
  logic [N_CTX-1:0]        ctx_active;
  logic [N_CTX-1:0]        ctx_done_pulse;
  logic [N_CTX-1:0]        ctx_is_write;
  logic [N_CTX*ADDR_W-1:0] ctx_addr;
  modport slave (
    input  alloc_valid, alloc_addr, alloc_len, alloc_is_write, issue_en, issue_id,
           free_en, free_id, set_recall_pending, clr_recall_pending,
    output alloc_ready, alloc_id, recall_pending, ctx_active, ctx_done_pulse,
           ctx_is_write, ctx_addr
  );
  modport master (
    output alloc_valid, alloc_addr, alloc_len, alloc_is_write, issue_en, issue_id,
           free_en, free_id, set_recall_pending, clr_recall_pending,
    input  alloc_ready, alloc_id, recall_pending, ctx_active, ctx_done_pulse,
           ctx_is_write, ctx_addr
  );
endinterface

// File: rtl/llc_dma_ctx_regs.sv
// llc_dma_ctx_regs: DMA context slots (IDLE/ACTIVE/DONE) with alloc, per-line issue and free.
// Define LLC_DMA_CTX_STATS_EN to add saturating read/write done counters.
module llc_dma_ctx_regs #(
  parameter int N_CTX  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_state,
  llc_dma_ctx_regs_if.slave bus
`ifdef LLC_DMA_CTX_STATS_EN
  ,
  output logic [31:0] stat_rd_done,
  output logic [31:0] stat_wr_done
`endif
);
  localparam int ID_W = $clog2(N_CTX);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  state_e            state_q [N_CTX];
  state_e            state_d [N_CTX];
  logic [ADDR_W-1:0] addr_q  [N_CTX];
  logic [ADDR_W-1:0] addr_d  [N_CTX];
  logic [LEN_W-1:0]  rem_q   [N_CTX];
  logic [LEN_W-1:0]  rem_d   [N_CTX];
  logic [N_CTX-1:0]  wr_q, wr_d, done_q, done_d, idle;
  logic              recall_q, recall_d, alloc_fire;
  logic [ID_W-1:0]   grant_id;
  always_comb begin
    idle = '0;
    grant_id = '0;
    for (int i = N_CTX - 1; i >= 0; i--) begin
      idle[i] = state_q[i] == IDLE;
      if (idle[i]) grant_id = ID_W'(i);
    end
  end
  // grants look only at registered state, so a slot freed this cycle is not yet visible
  assign bus.alloc_ready    = |idle && !recall_q && !rst_state;
  assign bus.alloc_id       = grant_id;
  assign alloc_fire         = bus.alloc_valid && bus.alloc_ready;
  assign bus.recall_pending = recall_q;
  assign bus.ctx_done_pulse = done_q;
  assign bus.ctx_is_write   = wr_q;
  always_comb begin
    recall_d = bus.clr_recall_pending ? 1'b0 : bus.set_recall_pending ? 1'b1 : recall_q;
    wr_d = wr_q;
    done_d = '0;
    for (int i = 0; i < N_CTX; i++) begin
      state_d[i] = state_q[i];
      addr_d[i] = addr_q[i];
      rem_d[i] = rem_q[i];
      if (alloc_fire && grant_id == ID_W'(i)) begin
        state_d[i] = ACTIVE;
        addr_d[i] = bus.alloc_addr;
        rem_d[i] = bus.alloc_len == '0 ? LEN_W'(1) : bus.alloc_len;
        wr_d[i] = bus.alloc_is_write;
      end
      if (bus.issue_en && bus.issue_id == ID_W'(i) && state_q[i] == ACTIVE) begin
        addr_d[i] = addr_q[i] + ADDR_W'(1);
        rem_d[i] = rem_q[i] - LEN_W'(1);
        state_d[i] = rem_q[i] == LEN_W'(1) ? DONE : ACTIVE;
        done_d[i] = rem_q[i] == LEN_W'(1);
      end
      if (bus.free_en && bus.free_id == ID_W'(i) && state_q[i] == DONE) state_d[i] = IDLE;
      if (rst_state) begin
        state_d[i] = IDLE;
        addr_d[i] = '0;
        rem_d[i] = '0;
      end
    end
    if (rst_state) begin
      recall_d = 1'b0;
      wr_d = '0;
      done_d = '0;
    end
  end
  always_comb begin
    bus.ctx_active = '0;
    bus.ctx_addr = '0;
    for (int i = 0; i < N_CTX; i++) begin
      bus.ctx_active[i] = state_q[i] == ACTIVE;
      bus.ctx_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CTX; i++) begin
        state_q[i] <= IDLE;
        addr_q[i] <= '0;
        rem_q[i] <= '0;
      end
      wr_q <= '0;
      done_q <= '0;
      recall_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CTX; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i] <= addr_d[i];
        rem_q[i] <= rem_d[i];
      end
      wr_q <= wr_d;
      done_q <= done_d;
      recall_q <= recall_d;
    end
  end
`ifdef LLC_DMA_CTX_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  // counted at completion; at most one slot completes per cycle since issue is single-ported
  always_comb begin
    rd_cnt_d = rst_state ? '0 : (|(done_d & ~wr_q) && rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = rst_state ? '0 : (|(done_d & wr_q) && wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  assign stat_rd_done = rd_cnt_q;
  assign stat_wr_done = wr_cnt_q;
`endif
endmodule

// File: doc/llc_dma_ctx_regs.md
LLC_DMA_CTX_REGS -- requirements
Module: llc_dma_ctx_regs

Interface
REQ-001 SHALL have parameter N_CTX, default 4, number of DMA context slots (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, line-address width.
REQ-003 SHALL have parameter LEN_W, default 8, transfer-length width in lines.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rst_state  in  1  synchronous clear of all state.
REQ-007 SHALL have ports alloc_valid in 1, alloc_addr in ADDR_W, alloc_len in LEN_W, alloc_is_write in 1: new DMA request.
REQ-008 SHALL have ports alloc_ready out 1 and alloc_id out $clog2(N_CTX): accept indication and the granted slot.
REQ-009 SHALL have ports issue_en in 1 and issue_id in $clog2(N_CTX): one line of slot issue_id transferred.
REQ-010 SHALL have ports free_en in 1 and free_id in $clog2(N_CTX): release a completed slot.
REQ-011 SHALL have ports set_recall_pending in 1, clr_recall_pending in 1, recall_pending out 1.
REQ-012 SHALL have outputs ctx_active, ctx_done_pulse, ctx_is_write (N_CTX each, one bit per slot) and ctx_addr (N_CTX*ADDR_W, slot i at bits [i*ADDR_W +: ADDR_W]).

Function
REQ-013 Each slot SHALL be an FSM with states IDLE, ACTIVE and DONE, holding addr (ADDR_W bits), remaining (LEN_W bits) and is_write.
REQ-014 alloc_ready SHALL be 1 iff at least one slot is IDLE at the start of the cycle, recall_pending=0 and rst_state=0.
REQ-015 alloc_id SHALL be combinational: the lowest-index IDLE slot.
REQ-016 On alloc_valid&&alloc_ready, that slot SHALL go ACTIVE next cycle with addr=alloc_addr, remaining=max(alloc_len,1) and is_write=alloc_is_write; alloc_len=0 SHALL be treated as 1.
REQ-017 On issue_en with slot issue_id ACTIVE, addr SHALL increment by 1 modulo 2^ADDR_W and remaining SHALL decrement by 1.
REQ-018 If remaining==1 at issue, the slot SHALL go DONE and ctx_done_pulse[id] SHALL be 1 for exactly the following cycle.
REQ-019 issue_en to a non-ACTIVE slot SHALL be ignored.
REQ-020 free_en to a DONE slot SHALL return it to IDLE next cycle; free_en to any other state SHALL be ignored.
REQ-021 A slot freed in cycle t SHALL NOT be grantable before cycle t+1.
REQ-022 Alloc, issue and free targeting different slots in the same cycle SHALL all take effect.
REQ-023 recall_pending: clr SHALL have priority over set; it SHALL hold otherwise.
REQ-024 ctx_active[i] SHALL be 1 iff slot i is ACTIVE.
REQ-025 ctx_addr and ctx_is_write SHALL hold their values while a slot is in DONE or IDLE.

Reset
REQ-026 On rst low, asynchronously, and on rst_state high, synchronously with priority over all other inputs: all slots SHALL go IDLE with addr=0, remaining=0, is_write=0; recall_pending=0; ctx_done_pulse=0.
REQ-027 A reset mid-transfer SHALL discard the slot with no done pulse.

Configuration
REQ-028 With LLC_DMA_CTX_STATS_EN defined, the block SHALL add outputs stat_rd_done and stat_wr_done (32 bits each). These SHALL count done pulses of read and write slots respectively, saturate at 2^32-1, and clear on reset or rst_state.
REQ-029 Without LLC_DMA_CTX_STATS_EN, these ports and counters SHALL be absent, with no other change in behaviour.

Verification
REQ-030 Reset then alloc addr=0x100, len=3, rd: alloc_id=0; after 3 issues ctx_addr[0]=0x103, one ctx_done_pulse[0]; free -> IDLE.
REQ-031 Four allocs with N_CTX=4: ids 0,1,2,3, then alloc_ready=0; free slot 2 when DONE: next grant is id 2 one cycle after the free, not in the same cycle.
REQ-032 alloc addr=0xFFFFFFFF, len=2: after issues ctx_addr=0x00000001 (wrap); alloc_len=0 completes after 1 issue.
REQ-033 set_recall_pending: alloc_ready=0 with idle slots present; set and clr in the same cycle -> recall_pending=0.
REQ-034 rst_state asserted with alloc, issue and free active: all slots IDLE next cycle, no done pulse, stats counters=0 (STATS_EN build).
REQ-035 Issue to an IDLE or DONE slot and free to an ACTIVE slot: no state change.
